mem_ring_agent: RTL and testbench
=================================

MEM_RING_AGENT -- requirements
Module: mem_ring_agent

Interface
REQ-001 SHALL have parameter DATA_W, default 512, ring and cache data width in bits.
REQ-002 SHALL have parameter NUM_IDS, default 16, number of request ids; fixed at 16 to match the 4-bit id field.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 req_valid  input  1  cache request offered.
REQ-007 req_ready  output  1  agent accepts request this cycle.
REQ-008 req_we  input  1  1=write, 0=read.
REQ-009 req_addr  input  36  line address.
REQ-010 req_data  input  DATA_W  write data; ignored for reads.
REQ-011 resp_valid  output  1  response held for cache.
REQ-012 resp_ready  input  1  cache takes response.
REQ-013 resp_we  output  1  1=write-ack, 0=read-data.
REQ-014 resp_addr  output  36  address of completed request.
REQ-015 resp_data  output  DATA_W  read data; zero for write-acks.
REQ-016 ring_type_in, ring_id_in, ring_addr_in, ring_data_in  input  3/4/36/DATA_W  incoming ring slot.
REQ-017 ring_type_out, ring_id_out, ring_addr_out, ring_data_out  output  3/4/36/DATA_W  outgoing ring slot, registered.

Function
REQ-018 Packet types SHALL be: 000 empty, 001 write request, 011 read request, 101 write-ack, 110 read-data; all others SHALL pass through unchanged.
REQ-019 One-entry request holding register: req_ready SHALL equal ~hold_valid; on req_valid & req_ready, capture we/addr/data.
REQ-020 Free-id mask of 16 bits, all free after reset; allocation SHALL pick the lowest free id.
REQ-021 Each cycle, the incoming slot SHALL be evaluated in priority: eject, inject, pass.
REQ-022 Eject: type 101/110 with ring_id_in allocated and response register empty or draining (resp_ready) SHALL load the response register, free the id, and make the outgoing slot empty.
REQ-023 Response arriving while response register full and resp_ready=0 SHALL pass through unchanged (recirculates).
REQ-024 Inject: if the slot is empty (incoming or freed by eject), hold_valid=1 and a free id exists, SHALL emit type 001/011, allocated id, hold addr/data, clear hold_valid, mark id busy -- same cycle.
REQ-025 Id freed by eject SHALL NOT be reallocated in the same cycle.
REQ-026 No free id: request SHALL remain held; req_ready stays 0.
REQ-027 Pass: otherwise slot SHALL be forwarded unchanged; latency in-to-out exactly 1 cycle in all cases.
REQ-028 Response for an unallocated id SHALL pass through unchanged.
REQ-029 resp_valid SHALL hold with stable payload until resp_valid & resp_ready.
REQ-030 req_ready SHALL rise the cycle after injection (registered hold_valid).

Reset
REQ-031 On rst_n low: hold_valid=0, req_ready=1 after release, resp_valid=0, resp_* =0, all ids free, ring_*_out =0 (empty).
REQ-032 Reset mid-operation SHALL drop in-flight requests and held responses without emitting partial packets.

Configuration
REQ-033 With MEM_RING_AGENT_PERF_EN defined: 32-bit saturating counters inj_cnt, ej_cnt, stall_cnt (cycles hold_valid=1 but no inject) SHALL be output ports, cleared by reset.
REQ-034 Without MEM_RING_AGENT_PERF_EN: no counter ports or logic; function otherwise identical.

Structure
REQ-035 Package mem_ring_pkg SHALL hold the packet-type enum, ring-slot struct (type/id/addr/data) and ADDR_W=36, ID_W=4.
REQ-036 Sub-module mem_ring_id_alloc SHALL implement the free mask, lowest-free encoder, alloc and free ports.

Verification
REQ-037 Read: req addr 0x0_0000_1040, we=0, empty ring -> next cycle ring_out type 011 id 0 addr 0x1040; inject type 110 id 0 data 0xA5.. -> resp_valid, resp_we=0, data 0xA5...
REQ-038 Write then ack: write addr 0x80 -> type 001 id 0; type 101 id 0 in -> resp_we=1, id 0 freed, outgoing slot 000.
REQ-039 Id exhaustion: 16 reads without responses -> ids 0..15, 17th held, req_ready=0 until any 110 ejected; reused id is the freed one, one cycle later.
REQ-040 Backpressure: resp_ready=0, two responses arrive -> first captured, second passes out unchanged with same id/type.
REQ-041 Busy ring: all incoming slots type 011 foreign id -> passed unchanged, request held, stall_cnt increments (PERF_EN).
REQ-042 Assert rst_n low with 3 ids busy and resp_valid=1 -> all outputs zero, mask all free, next request gets id 0.

Source files
------------

// File: rtl/mem_ring_pkg.sv
// Shared types and constants for the memory ring agent.
// Holds the ring packet-type encoding, the ring slot layout and the
// address / id field widths used by the agent, its interface and sub-modules.
package mem_ring_pkg;

  localparam int ADDR_W      = 36;
  localparam int ID_W        = 4;
  // Widest data payload a ring slot can carry; DATA_W of the agent must not exceed it.
  localparam int SLOT_DATA_W = 512;

  typedef enum logic [2:0] {
    PKT_EMPTY   = 3'b000,
    PKT_WR_REQ  = 3'b001,
    PKT_RD_REQ  = 3'b011,
    PKT_WR_ACK  = 3'b101,
    PKT_RD_DATA = 3'b110
  } pkt_type_e;

  // Type kept as raw bits so unknown encodings travel around the ring untouched.
  typedef struct packed {
    logic [2:0]             ptype;
    logic [ID_W-1:0]        id;
    logic [ADDR_W-1:0]      addr;
    logic [SLOT_DATA_W-1:0] data;
  } ring_slot_t;

  // True for the two packet types that complete an outstanding request.
  function automatic logic is_resp(input logic [2:0] t);
    return (t == PKT_WR_ACK) || (t == PKT_RD_DATA);
  endfunction

endpackage

// File: rtl/mem_ring_agent_if.sv
// Cache-side request/response handshakes and the ring slot in/out buses
// of the memory ring agent. slave = agent side, master = cache/ring side.
interface mem_ring_agent_if
  import mem_ring_pkg::*;
#(
  parameter int DATA_W = 512
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_data;

  logic              resp_valid;
  logic              resp_ready;
  logic              resp_we;
  logic [ADDR_W-1:0] resp_addr;
  logic [DATA_W-1:0] resp_data;

  logic [2:0]        ring_type_in;
  logic [ID_W-1:0]   ring_id_in;
  logic [ADDR_W-1:0] ring_addr_in;
  logic [DATA_W-1:0] ring_data_in;

  logic [2:0]        ring_type_out;
  logic [ID_W-1:0]   ring_id_out;
  logic [ADDR_W-1:0] ring_addr_out;
  logic [DATA_W-1:0] ring_data_out;

  modport slave (
    input  req_valid, req_we, req_addr, req_data,
    output req_ready,
    output resp_valid, resp_we, resp_addr, resp_data,
    input  resp_ready,
    input  ring_type_in, ring_id_in, ring_addr_in, ring_data_in,
    output ring_type_out, ring_id_out, ring_addr_out, ring_data_out
  );

  modport master (
    output req_valid, req_we, req_addr, req_data,
    input  req_ready,
    input  resp_valid, resp_we, resp_addr, resp_data,
    output resp_ready,
    output ring_type_in, ring_id_in, ring_addr_in, ring_data_in,
    input  ring_type_out, ring_id_out, ring_addr_out, ring_data_out
  );

endinterface

// File: rtl/mem_ring_id_alloc.sv
// Request-id allocator: free mask (1 = free), lowest-free encoder,
// one alloc and one free per cycle. The encoder looks at the registered
// mask only, so an id freed this cycle cannot be handed out until the next.
module mem_ring_id_alloc
  import mem_ring_pkg::*;
#(
  parameter int NUM_IDS = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_alloc,
  input  logic               i_free,
  input  logic [ID_W-1:0]    i_free_id,
  output logic               o_any_free,
  output logic [ID_W-1:0]    o_alloc_id,
  output logic [NUM_IDS-1:0] o_free_mask
);

  logic [NUM_IDS-1:0] r_free_mask;
  logic [NUM_IDS-1:0] w_mask_next;
  logic [ID_W-1:0]    w_alloc_id;

  // Lowest free id wins: scan downward so the last hit is the smallest index.
  always_comb begin
    w_alloc_id = '0;
    for (int i = NUM_IDS - 1; i >= 0; i--) begin
      if (r_free_mask[i]) w_alloc_id = ID_W'(i);
    end
  end

  // Per-id next state: a free always sets, an alloc of this id clears.
  for (genvar gi = 0; gi < NUM_IDS; gi++) begin : g_mask
    assign w_mask_next[gi] = (i_free && (i_free_id == ID_W'(gi))) ? 1'b1 :
                             (i_alloc && (w_alloc_id == ID_W'(gi))) ? 1'b0 :
                             r_free_mask[gi];
  end

  // Mask register; every id is free out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_free_mask <= '1;
    else        r_free_mask <= w_mask_next;
  end

  assign o_any_free  = |r_free_mask;
  assign o_alloc_id  = w_alloc_id;
  assign o_free_mask = r_free_mask;

endmodule

// File: rtl/mem_ring_agent.sv
// Memory ring agent: turns one held cache request into a ring request
// packet with a fresh id, and ejects matching write-acks / read-data back
// to the cache through a one-entry response register. Every ring slot is
// registered, giving a fixed one-cycle in-to-out latency.
// Optional performance counters are built when MEM_RING_AGENT_PERF_EN is defined.
module mem_ring_agent
  import mem_ring_pkg::*;
#(
  parameter int DATA_W  = 512,
  parameter int NUM_IDS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  mem_ring_agent_if.slave   bus
`ifdef MEM_RING_AGENT_PERF_EN
  ,
  output logic [31:0]       inj_cnt,
  output logic [31:0]       ej_cnt,
  output logic [31:0]       stall_cnt
`endif
);

  logic              r_hold_valid;
  logic              r_hold_we;
  logic [ADDR_W-1:0] r_hold_addr;
  logic [DATA_W-1:0] r_hold_data;

  logic              r_resp_valid;
  logic              r_resp_we;
  logic [ADDR_W-1:0] r_resp_addr;
  logic [DATA_W-1:0] r_resp_data;

  ring_slot_t        r_slot;
  ring_slot_t        w_slot_next;

  logic               w_any_free;
  logic [ID_W-1:0]    w_alloc_id;
  logic [NUM_IDS-1:0] w_free_mask;

  logic w_in_resp;
  logic w_id_busy;
  logic w_resp_room;
  logic w_eject;
  logic w_slot_free;
  logic w_inject;
  logic w_accept;

  mem_ring_id_alloc #(
    .NUM_IDS (NUM_IDS)
  ) u_id_alloc (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_alloc     (w_inject),
    .i_free      (w_eject),
    .i_free_id   (bus.ring_id_in),
    .o_any_free  (w_any_free),
    .o_alloc_id  (w_alloc_id),
    .o_free_mask (w_free_mask)
  );

  // Slot decision in priority order eject > inject > pass.
  always_comb begin
    w_in_resp   = is_resp(bus.ring_type_in);
    w_id_busy   = ~w_free_mask[bus.ring_id_in];
    w_resp_room = ~r_resp_valid | bus.resp_ready;
    w_eject     = w_in_resp & w_id_busy & w_resp_room;
    w_slot_free = (bus.ring_type_in == PKT_EMPTY) | w_eject;
    w_inject    = w_slot_free & r_hold_valid & w_any_free;
    w_accept    = bus.req_valid & ~r_hold_valid;

    w_slot_next = '0;
    if (w_inject) begin
      w_slot_next.ptype              = r_hold_we ? PKT_WR_REQ : PKT_RD_REQ;
      w_slot_next.id                 = w_alloc_id;
      w_slot_next.addr               = r_hold_addr;
      w_slot_next.data[DATA_W-1:0]   = r_hold_data;
    end else if (!w_eject) begin
      w_slot_next.ptype              = bus.ring_type_in;
      w_slot_next.id                 = bus.ring_id_in;
      w_slot_next.addr               = bus.ring_addr_in;
      w_slot_next.data[DATA_W-1:0]   = bus.ring_data_in;
    end
  end

  // Outgoing ring slot register; an ejected slot leaves as an all-zero empty packet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_slot <= '0;
    else        r_slot <= w_slot_next;
  end

  // One-entry request holding register; it empties only when its packet is injected.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold_valid <= 1'b0;
      r_hold_we    <= 1'b0;
      r_hold_addr  <= '0;
      r_hold_data  <= '0;
    end else if (w_accept) begin
      r_hold_valid <= 1'b1;
      r_hold_we    <= bus.req_we;
      r_hold_addr  <= bus.req_addr;
      r_hold_data  <= bus.req_data;
    end else if (w_inject) begin
      r_hold_valid <= 1'b0;
    end
  end

  // Response register; payload stays put until the cache takes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_valid <= 1'b0;
      r_resp_we    <= 1'b0;
      r_resp_addr  <= '0;
      r_resp_data  <= '0;
    end else if (w_eject) begin
      r_resp_valid <= 1'b1;
      r_resp_we    <= (bus.ring_type_in == PKT_WR_ACK);
      r_resp_addr  <= bus.ring_addr_in;
      r_resp_data  <= (bus.ring_type_in == PKT_WR_ACK) ? '0 : bus.ring_data_in;
    end else if (r_resp_valid && bus.resp_ready) begin
      r_resp_valid <= 1'b0;
    end
  end

`ifdef MEM_RING_AGENT_PERF_EN
  logic [31:0] r_inj_cnt;
  logic [31:0] r_ej_cnt;
  logic [31:0] r_stall_cnt;

  // Saturating event counters: injections, ejections, held-but-blocked cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inj_cnt   <= '0;
      r_ej_cnt    <= '0;
      r_stall_cnt <= '0;
    end else begin
      if (w_inject && (r_inj_cnt != '1)) r_inj_cnt <= r_inj_cnt + 32'd1;
      if (w_eject && (r_ej_cnt != '1))   r_ej_cnt  <= r_ej_cnt + 32'd1;
      if (r_hold_valid && !w_inject && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign inj_cnt   = r_inj_cnt;
  assign ej_cnt    = r_ej_cnt;
  assign stall_cnt = r_stall_cnt;
`endif

  assign bus.req_ready     = ~r_hold_valid;
  assign bus.resp_valid    = r_resp_valid;
  assign bus.resp_we       = r_resp_we;
  assign bus.resp_addr     = r_resp_addr;
  assign bus.resp_data     = r_resp_data;
  assign bus.ring_type_out = r_slot.ptype;
  assign bus.ring_id_out   = r_slot.id;
  assign bus.ring_addr_out = r_slot.addr;
  assign bus.ring_data_out = r_slot.data[DATA_W-1:0];

endmodule

// File: tb/tb_mem_ring_agent.sv
// Directed bench for mem_ring_agent: a per-cycle vector table followed by
// hand-written sequences for id exhaustion and reset in mid-operation.
// Counter checks are included when MEM_RING_AGENT_PERF_EN is defined.
module tb_mem_ring_agent;
  import mem_ring_pkg::*;

  localparam int DW = 512;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  mem_ring_agent_if #(.DATA_W(DW)) bus ();

`ifdef MEM_RING_AGENT_PERF_EN
  logic [31:0] inj_cnt;
  logic [31:0] ej_cnt;
  logic [31:0] stall_cnt;
`endif

  mem_ring_agent #(
    .DATA_W  (DW),
    .NUM_IDS (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef MEM_RING_AGENT_PERF_EN
    ,
    .inj_cnt   (inj_cnt),
    .ej_cnt    (ej_cnt),
    .stall_cnt (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rv;
    logic        rwe;
    logic [35:0] raddr;
    logic [7:0]  rdb;
    logic [2:0]  tin;
    logic [3:0]  idin;
    logic [35:0] ain;
    logic [7:0]  dinb;
    logic        rr;
    logic        e_rdy;
    logic        e_rv;
    logic        e_rwe;
    logic [35:0] e_raddr;
    logic [7:0]  e_rdb;
    logic [2:0]  e_t;
    logic [3:0]  e_id;
    logic [35:0] e_a;
    logic [7:0]  e_db;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  function automatic logic [DW-1:0] rep(input logic [7:0] b);
    return {64{b}};
  endfunction

  function automatic vec_t mk(
    input logic rv, input logic rwe, input logic [35:0] raddr, input logic [7:0] rdb,
    input logic [2:0] tin, input logic [3:0] idin, input logic [35:0] ain,
    input logic [7:0] dinb, input logic rr,
    input logic e_rdy, input logic e_rv, input logic e_rwe, input logic [35:0] e_raddr,
    input logic [7:0] e_rdb, input logic [2:0] e_t, input logic [3:0] e_id,
    input logic [35:0] e_a, input logic [7:0] e_db);
    vec_t v;
    v.rv = rv; v.rwe = rwe; v.raddr = raddr; v.rdb = rdb;
    v.tin = tin; v.idin = idin; v.ain = ain; v.dinb = dinb; v.rr = rr;
    v.e_rdy = e_rdy; v.e_rv = e_rv; v.e_rwe = e_rwe; v.e_raddr = e_raddr;
    v.e_rdb = e_rdb; v.e_t = e_t; v.e_id = e_id; v.e_a = e_a; v.e_db = e_db;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic chkw(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", nm, act[63:0], exp[63:0]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.req_valid    = 1'b0;
    bus.req_we       = 1'b0;
    bus.req_addr     = '0;
    bus.req_data     = '0;
    bus.resp_ready   = 1'b1;
    bus.ring_type_in = 3'b000;
    bus.ring_id_in   = '0;
    bus.ring_addr_in = '0;
    bus.ring_data_in = '0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".req_ready"},  64'(bus.req_ready), 64'd1);
    chk({tag, ".resp_valid"}, 64'(bus.resp_valid), 64'd0);
    chk({tag, ".resp_we"},    64'(bus.resp_we), 64'd0);
    chk({tag, ".resp_addr"},  64'(bus.resp_addr), 64'd0);
    chkw({tag, ".resp_data"}, bus.resp_data, '0);
    chk({tag, ".type_out"},   64'(bus.ring_type_out), 64'd0);
    chk({tag, ".id_out"},     64'(bus.ring_id_out), 64'd0);
    chk({tag, ".addr_out"},   64'(bus.ring_addr_out), 64'd0);
    chkw({tag, ".data_out"},  bus.ring_data_out, '0);
  endtask

  task automatic do_reset();
    drive_idle();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n    = 1'b0;
    drive_idle();

    //      rv rwe raddr       rdb    tin   id ain         dinb   rr  | rdy rv rwe raddr     rdb    t     id a           db
    vecs[0]  = mk(1,0,36'h0_0000_1040,8'h00, 3'd0,4'd0,36'h0,      8'h00, 1,  0,0,0,36'h0,    8'h00, 3'd0,4'd0,36'h0,    8'h00);
    vecs[1]  = mk(0,0,36'h0,          8'h00, 3'd0,4'd0,36'h0,      8'h00, 1,  1,0,0,36'h0,    8'h00, 3'd3,4'd0,36'h1040, 8'h00);
    vecs[2]  = mk(0,0,36'h0,          8'h00, 3'd6,4'd0,36'h1040,   8'hA5, 0,  1,1,0,36'h1040, 8'hA5, 3'd0,4'd0,36'h0,    8'h00);
    vecs[3]  = mk(1,1,36'h80,         8'h3C, 3'd0,4'd0,36'h0,      8'h00, 1,  0,0,0,36'h0,    8'h00, 3'd0,4'd0,36'h0,    8'h00);
    vecs[4]  = mk(0,0,36'h0,          8'h00, 3'd0,4'd0,36'h0,      8'h00, 1,  1,0,0,36'h0,    8'h00, 3'd1,4'd0,36'h80,   8'h3C);
    vecs[5]  = mk(0,0,36'h0,          8'h00, 3'd5,4'd0,36'h80,     8'h77, 0,  1,1,1,36'h80,   8'h00, 3'd0,4'd0,36'h0,    8'h00);
    vecs[6]  = mk(0,0,36'h0,          8'h00, 3'd0,4'd0,36'h0,      8'h00, 1,  1,0,0,36'h0,    8'h00, 3'd0,4'd0,36'h0,    8'h00);
    vecs[7]  = mk(1,0,36'h100,        8'h00, 3'd0,4'd0,36'h0,      8'h00, 1,  0,0,0,36'h0,    8'h00, 3'd0,4'd0,36'h0,    8'h00);
    vecs[8]  = mk(1,0,36'h200,        8'h00, 3'd0,4'd0,36'h0,      8'h00, 1,  1,0,0,36'h0,    8'h00, 3'd3,4'd0,36'h100,  8'h00);
    vecs[9]  = mk(1,0,36'h200,        8'h00, 3'd0,4'd0,36'h0,      8'h00, 1,  0,0,0,36'h0,    8'h00, 3'd0,4'd0,36'h0,    8'h00);
    vecs[10] = mk(0,0,36'h0,          8'h00, 3'd0,4'd0,36'h0,      8'h00, 1,  1,0,0,36'h0,    8'h00, 3'd3,4'd1,36'h200,  8'h00);
    vecs[11] = mk(0,0,36'h0,          8'h00, 3'd6,4'd0,36'h100,    8'h11, 0,  1,1,0,36'h100,  8'h11, 3'd0,4'd0,36'h0,    8'h00);
    vecs[12] = mk(0,0,36'h0,          8'h00, 3'd6,4'd1,36'h200,    8'h22, 0,  1,1,0,36'h100,  8'h11, 3'd6,4'd1,36'h200,  8'h22);
    vecs[13] = mk(0,0,36'h0,          8'h00, 3'd6,4'd1,36'h200,    8'h22, 1,  1,1,0,36'h200,  8'h22, 3'd0,4'd0,36'h0,    8'h00);
    vecs[14] = mk(0,0,36'h0,          8'h00, 3'd0,4'd0,36'h0,      8'h00, 1,  1,0,0,36'h0,    8'h00, 3'd0,4'd0,36'h0,    8'h00);
    vecs[15] = mk(0,0,36'h0,          8'h00, 3'd6,4'd5,36'h555,    8'h33, 1,  1,0,0,36'h0,    8'h00, 3'd6,4'd5,36'h555,  8'h33);
    vecs[16] = mk(0,0,36'h0,          8'h00, 3'd7,4'd9,36'h999,    8'h44, 1,  1,0,0,36'h0,    8'h00, 3'd7,4'd9,36'h999,  8'h44);
    vecs[17] = mk(1,0,36'h300,        8'h00, 3'd3,4'd3,36'hABC,    8'h55, 1,  0,0,0,36'h0,    8'h00, 3'd3,4'd3,36'hABC,  8'h55);
    vecs[18] = mk(0,0,36'h0,          8'h00, 3'd3,4'd3,36'hABC,    8'h55, 1,  0,0,0,36'h0,    8'h00, 3'd3,4'd3,36'hABC,  8'h55);
    vecs[19] = mk(0,0,36'h0,          8'h00, 3'd1,4'd7,36'h777,    8'h66, 1,  0,0,0,36'h0,    8'h00, 3'd1,4'd7,36'h777,  8'h66);
    vecs[20] = mk(0,0,36'h0,          8'h00, 3'd0,4'd0,36'h0,      8'h00, 1,  1,0,0,36'h0,    8'h00, 3'd3,4'd0,36'h300,  8'h00);

    // Reset state, checked while reset is still asserted.
    step();
    step();
    chk_all_zero("reset");
`ifdef MEM_RING_AGENT_PERF_EN
    chk("reset.inj_cnt", 64'(inj_cnt), 64'd0);
    chk("reset.stall_cnt", 64'(stall_cnt), 64'd0);
`endif
    rst_n = 1'b1;

    // Table-driven cycles.
    for (int i = 0; i < NV; i++) begin
      bus.req_valid    = vecs[i].rv;
      bus.req_we       = vecs[i].rwe;
      bus.req_addr     = vecs[i].raddr;
      bus.req_data     = rep(vecs[i].rdb);
      bus.ring_type_in = vecs[i].tin;
      bus.ring_id_in   = vecs[i].idin;
      bus.ring_addr_in = vecs[i].ain;
      bus.ring_data_in = rep(vecs[i].dinb);
      bus.resp_ready   = vecs[i].rr;
      step();
      $display("vec %0d: in type %0d id %0d -> out type %0d id %0d addr %h, req_ready %0d resp_valid %0d",
               i, vecs[i].tin, vecs[i].idin, bus.ring_type_out, bus.ring_id_out,
               bus.ring_addr_out, bus.req_ready, bus.resp_valid);
      chk($sformatf("v%0d.req_ready", i),  64'(bus.req_ready), 64'(vecs[i].e_rdy));
      chk($sformatf("v%0d.resp_valid", i), 64'(bus.resp_valid), 64'(vecs[i].e_rv));
      if (vecs[i].e_rv) begin
        chk($sformatf("v%0d.resp_we", i),    64'(bus.resp_we), 64'(vecs[i].e_rwe));
        chk($sformatf("v%0d.resp_addr", i),  64'(bus.resp_addr), 64'(vecs[i].e_raddr));
        chkw($sformatf("v%0d.resp_data", i), bus.resp_data, rep(vecs[i].e_rdb));
      end
      chk($sformatf("v%0d.type_out", i),  64'(bus.ring_type_out), 64'(vecs[i].e_t));
      chk($sformatf("v%0d.id_out", i),    64'(bus.ring_id_out), 64'(vecs[i].e_id));
      chk($sformatf("v%0d.addr_out", i),  64'(bus.ring_addr_out), 64'(vecs[i].e_a));
      chkw($sformatf("v%0d.data_out", i), bus.ring_data_out, rep(vecs[i].e_db));
    end
`ifdef MEM_RING_AGENT_PERF_EN
    chk("perf.inj_cnt", 64'(inj_cnt), 64'd5);
    chk("perf.ej_cnt", 64'(ej_cnt), 64'd4);
    chk("perf.stall_cnt", 64'(stall_cnt), 64'd2);
`endif

    // Id exhaustion: 16 reads take ids 0..15, the 17th is held.
    do_reset();
    for (int k = 0; k < 16; k++) begin
      bus.req_valid = 1'b1;
      bus.req_addr  = 36'h1000 + 36'(k);
      step();
      bus.req_valid = 1'b0;
      step();
      $display("exhaust %0d: out type %0d id %0d addr %h", k, bus.ring_type_out,
               bus.ring_id_out, bus.ring_addr_out);
      chk($sformatf("ex%0d.type", k), 64'(bus.ring_type_out), 64'd3);
      chk($sformatf("ex%0d.id", k),   64'(bus.ring_id_out), 64'(k));
      chk($sformatf("ex%0d.addr", k), 64'(bus.ring_addr_out), 64'h1000 + 64'(k));
    end
    bus.req_valid = 1'b1;
    bus.req_addr  = 36'h2000;
    step();
    bus.req_valid = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      $display("held %0d: out type %0d req_ready %0d", k, bus.ring_type_out, bus.req_ready);
      chk($sformatf("held%0d.type", k),      64'(bus.ring_type_out), 64'd0);
      chk($sformatf("held%0d.req_ready", k), 64'(bus.req_ready), 64'd0);
    end
    // Eject id 7: freed this cycle but not reused until the next one.
    bus.ring_type_in = 3'b110;
    bus.ring_id_in   = 4'd7;
    bus.ring_addr_in = 36'h1007;
    bus.ring_data_in = rep(8'h99);
    bus.resp_ready   = 1'b0;
    step();
    $display("eject id7: out type %0d resp_valid %0d", bus.ring_type_out, bus.resp_valid);
    chk("ej7.type_out", 64'(bus.ring_type_out), 64'd0);
    chk("ej7.resp_valid", 64'(bus.resp_valid), 64'd1);
    chkw("ej7.resp_data", bus.resp_data, rep(8'h99));
    chk("ej7.req_ready", 64'(bus.req_ready), 64'd0);
    bus.ring_type_in = 3'b000;
    bus.ring_id_in   = 4'd0;
    bus.ring_addr_in = '0;
    bus.ring_data_in = '0;
    step();
    $display("reuse: out type %0d id %0d addr %h", bus.ring_type_out, bus.ring_id_out, bus.ring_addr_out);
    chk("reuse.type", 64'(bus.ring_type_out), 64'd3);
    chk("reuse.id", 64'(bus.ring_id_out), 64'd7);
    chk("reuse.addr", 64'(bus.ring_addr_out), 64'h2000);
    chk("reuse.req_ready", 64'(bus.req_ready), 64'd1);
    step();
    chk("hold.resp_valid", 64'(bus.resp_valid), 64'd1);
    chk("hold.resp_addr", 64'(bus.resp_addr), 64'h1007);
    chkw("hold.resp_data", bus.resp_data, rep(8'h99));

    // Reset in mid-operation: all ids busy and a response pending.
    #2;
    rst_n = 1'b0;
    #1;
    $display("async reset: resp_valid %0d type_out %0d", bus.resp_valid, bus.ring_type_out);
    chk_all_zero("midrst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    bus.resp_ready = 1'b1;
    bus.req_valid  = 1'b1;
    bus.req_addr   = 36'h40;
    step();
    bus.req_valid = 1'b0;
    step();
    $display("post-reset read: out type %0d id %0d addr %h", bus.ring_type_out,
             bus.ring_id_out, bus.ring_addr_out);
    chk("postrst.type", 64'(bus.ring_type_out), 64'd3);
    chk("postrst.id", 64'(bus.ring_id_out), 64'd0);
    chk("postrst.addr", 64'(bus.ring_addr_out), 64'h40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
